// File: rtl/calendar_ctrl.sv
// Purpose : month/day calendar with a three-state edit FSM (RUN, SET_MONTH, SET_DAY).
// Latency : one CLK edge from a sampled pulse to its effect on any output; all outputs registered.
// Backpr. : none; pulses are consumed on the edge they are sampled. DAY_TICK is dropped while editing.
//
// Ports:
//   CLK       in  1  system clock, rising edge
//   RESETN    in  1  asynchronous active-low reset
//   DAY_TICK  in  1  pulse, advance the date by one day (RUN only)
//   MODE      in  1  pulse, step RUN -> SET_MONTH -> SET_DAY -> RUN
//   UP        in  1  pulse, increment the field being edited
//   LEAP      in  1  level, February has 29 days when high
//   MONTH     out 7  binary month 1..12
//   DAY       out 7  binary day 1..max(MONTH)
//   EDIT_SEL  out 2  00 run, 01 editing month, 10 editing day
//   ROLLOVER  out 1  pulse on the Dec 31 -> Jan 1 wrap
module calendar_ctrl (
   input  logic       CLK,
   input  logic       RESETN,
   input  logic       DAY_TICK,
   input  logic       MODE,
   input  logic       UP,
   input  logic       LEAP,
   output logic [6:0] MONTH,
   output logic [6:0] DAY,
   output logic [1:0] EDIT_SEL,
   output logic       ROLLOVER
);

   // State encoding doubles as the EDIT_SEL output code.
   typedef enum logic [1:0] {
      ST_RUN       = 2'b00,
      ST_SET_MONTH = 2'b01,
      ST_SET_DAY   = 2'b10
   } state_t;

   state_t     r_state;
   logic [6:0] r_month;
   logic [6:0] r_day;
   logic       r_rollover;

   logic [6:0] w_max_day;
   logic       w_clamp;
   logic [6:0] w_month_inc;

   // Length of the currently registered month.
   always_comb begin
      w_max_day = 7'd31;
      case (r_month)
         7'd2:                     w_max_day = 7'd28 + {6'd0, LEAP};
         7'd4, 7'd6, 7'd9, 7'd11:  w_max_day = 7'd30;
         default:                  w_max_day = 7'd31;
      endcase
   end

   // Day is out of range after a month edit or LEAP dropping while on Feb 29.
   assign w_clamp     = (r_day > w_max_day);
   assign w_month_inc = (r_month == 7'd12) ? 7'd1 : r_month + 7'd1;

   always_ff @(posedge CLK or negedge RESETN) begin
      if (!RESETN) begin
         r_state    <= ST_RUN;
         r_month    <= 7'd1;
         r_day      <= 7'd1;
         r_rollover <= 1'b0;
      end else begin
         r_rollover <= 1'b0;

         // MODE is processed independently of the date datapath so that
         // MODE and DAY_TICK in RUN both take effect.
         if (MODE) begin
            case (r_state)
               ST_RUN:       r_state <= ST_SET_MONTH;
               ST_SET_MONTH: r_state <= ST_SET_DAY;
               default:      r_state <= ST_RUN;
            endcase
         end

         if (w_clamp) begin
            // Clamp beats any UP or DAY_TICK sampled in the same cycle.
            r_day <= w_max_day;
         end else begin
            case (r_state)
               ST_RUN: begin
                  if (DAY_TICK) begin
                     if (r_day < w_max_day) begin
                        r_day <= r_day + 7'd1;
                     end else begin
                        r_day      <= 7'd1;
                        r_month    <= w_month_inc;
                        r_rollover <= (r_month == 7'd12);
                     end
                  end
               end
               ST_SET_MONTH: begin
                  // MODE wins over a simultaneous UP.
                  if (UP && !MODE) begin
                     r_month <= w_month_inc;
                  end
               end
               default: begin
                  if (UP && !MODE) begin
                     r_day <= (r_day >= w_max_day) ? 7'd1 : r_day + 7'd1;
                  end
               end
            endcase
         end
      end
   end

   assign MONTH    = r_month;
   assign DAY      = r_day;
   assign EDIT_SEL = r_state;
   assign ROLLOVER = r_rollover;

endmodule

// File: doc/calendar_ctrl.md
CALENDAR_CTRL -- requirements
Module: calendar_ctrl

Interface
REQ-001 The block SHALL have exactly one clock and an asynchronous, active-low reset; ports as follows.
REQ-002 CLK       in   1  system clock; all state updates on its rising edge.
REQ-003 RESETN    in   1  asynchronous active-low reset.
REQ-004 DAY_TICK  in   1  one-CLK pulse; advance date by one day.
REQ-005 MODE      in   1  one-CLK pulse; step edit mode.
REQ-006 UP        in   1  one-CLK pulse; increment the field being edited.
REQ-007 LEAP      in   1  level; 1 = February has 29 days, 0 = 28.
REQ-008 MONTH     out  7  binary month 1..12, registered; feeds the digit separator directly.
REQ-009 DAY       out  7  binary day 1..31, registered; feeds the digit separator directly.
REQ-010 EDIT_SEL  out  2  00 = run, 01 = editing month, 10 = editing day; 11 never driven.
REQ-011 ROLLOVER  out  1  one-CLK pulse on year wrap (Dec 31 -> Jan 1).

Function
REQ-012 The FSM SHALL have three states: RUN, SET_MONTH and SET_DAY; EDIT_SEL is 00, 01 and 10 respectively.
REQ-013 A MODE pulse SHALL cause these transitions: RUN->SET_MONTH, SET_MONTH->SET_DAY, SET_DAY->RUN; the new state is visible on the following edge.
REQ-014 Month length max(M) SHALL be:
- 31 for months 1, 3, 5, 7, 8, 10 and 12;
- 30 for months 4, 6, 9 and 11;
- 28 + LEAP for month 2.
REQ-015 In RUN, on DAY_TICK:
- DAY < max(MONTH): DAY += 1;
- otherwise DAY = 1 and MONTH += 1;
- MONTH 12 wraps to 1, and ROLLOVER = 1 for exactly that cycle.
REQ-016 In SET_MONTH and SET_DAY, DAY_TICK SHALL be ignored (time lost); ROLLOVER stays 0.
REQ-017 In SET_MONTH, UP SHALL set MONTH += 1 (12 wraps to 1); DAY is unchanged except as clamped per REQ-019.
REQ-018 In SET_DAY, UP SHALL set DAY += 1, wrapping from max(MONTH) to 1; MONTH is unchanged.
REQ-019 Clamp: in every state, if the registered DAY > max(MONTH) (month change or LEAP falling), DAY SHALL be forced to max(MONTH) on the next edge; clamping takes priority over any UP or DAY_TICK in that cycle.
REQ-020 Simultaneous MODE and UP: MODE SHALL win and UP is discarded.
REQ-021 Simultaneous MODE and DAY_TICK in RUN: both SHALL take effect (date advances, state goes to SET_MONTH).
REQ-022 UP in RUN SHALL be ignored.
REQ-023 Latency: every output SHALL reflect a sampled pulse one edge after it is sampled; there are no combinational input-to-output paths.
REQ-024 MONTH and DAY SHALL never leave 1..12 and 1..max(MONTH) except during the single clamp cycle of REQ-019; the upper 3 bits of MONTH and upper 2 bits of DAY are always 0.

Reset
REQ-025 While RESETN = 0, regardless of CLK, the block SHALL hold: state = RUN, MONTH = 1, DAY = 1, EDIT_SEL = 00, ROLLOVER = 0.
REQ-026 Reset asserted mid-edit SHALL abandon the edit with no partial update retained.
REQ-027 After reset release, the first active edge SHALL process inputs normally.

Verification
REQ-028 Power-up: RESETN low then released -> MONTH = 1, DAY = 1, EDIT_SEL = 00, ROLLOVER = 0.
REQ-029 Run at Jan 31 with one DAY_TICK -> MONTH = 2, DAY = 1.
REQ-030 Feb 28, DAY_TICK:
- LEAP = 0 -> Mar 1;
- LEAP = 1 -> Feb 29, then a further DAY_TICK -> Mar 1.
REQ-031 Dec 31, DAY_TICK -> Jan 1, with ROLLOVER high for exactly 1 cycle.
REQ-032 Edit sequence from Jan 31, LEAP = 0:
- MODE, then UP -> MONTH = 2, DAY clamped to 28;
- DAY_TICK in this state -> no change;
- MODE, then UP -> DAY wraps to 1;
- MODE -> EDIT_SEL = 00.
REQ-033 In SET_DAY with DAY = 15, assert RESETN low asynchronously -> outputs return to 1/1/00 immediately, without waiting for a CLK edge.
